// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if - shared-memory request/ready handshake.
// The controller drives the request side, memory answers with mem_ready.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_write;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller - multi-cycle RV32I control FSM with memory timeout.
// Define CTRL_JUMP_EN to add JAL, JALR and LUI sequencing.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       msb,
  input  logic       sltu,
  multicycle_controller_if.master bus,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_TRAP
`ifdef CTRL_JUMP_EN
    , S_JALRADR, S_JUMP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo;

  logic is_ld, is_st, is_r, is_i, is_br, is_jal;
  assign is_ld  = opcode == OP_LD;
  assign is_st  = opcode == OP_ST;
  assign is_r   = opcode == OP_R;
  assign is_i   = opcode == OP_I;
  assign is_br  = opcode == OP_BR;
  assign is_jal = opcode == OP_JAL;

`ifdef CTRL_JUMP_EN
  logic is_jalr, is_lui;
  assign is_jalr = opcode == 7'b1100111;
  assign is_lui  = opcode == 7'b0110111;
`endif

  // Last waiting cycle before the limit; a late mem_ready still wins.
  assign tmo = (MEM_TIMEOUT != 0) && !bus.mem_ready &&
               (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  assign trap       = state_q == S_TRAP;
  assign trap_cause = cause_q;

  function automatic logic [3:0] alu_dec(
    input logic [2:0] f3, input logic f7, input logic r
  );
    unique case (f3)
      3'b000:  alu_dec = (r && f7) ? 4'd1 : 4'd0;
      3'b001:  alu_dec = 4'd2;
      3'b010:  alu_dec = 4'd3;
      3'b011:  alu_dec = 4'd4;
      3'b100:  alu_dec = 4'd5;
      3'b101:  alu_dec = f7 ? 4'd7 : 4'd6;
      3'b110:  alu_dec = 4'd8;
      default: alu_dec = 4'd9;
    endcase
  endfunction

  function automatic logic br_taken(
    input logic [2:0] f3, input logic z, input logic m, input logic u
  );
    unique case (f3)
      3'b000:  br_taken = z;
      3'b001:  br_taken = !z;
      3'b100:  br_taken = m;
      3'b101:  br_taken = !m;
      3'b110:  br_taken = u;
      3'b111:  br_taken = !u;
      default: br_taken = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cause_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP && state_q != S_TRAP)
        cause_q <= cause_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (bus.mem_req && !bus.mem_ready)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_ld, is_st: state_d = S_MEMADR;
          is_r:         state_d = S_EXECR;
          is_i:         state_d = S_EXECI;
          is_br:        state_d = S_BRANCH;
`ifdef CTRL_JUMP_EN
          is_jal:       state_d = S_JUMP;
          is_jalr:      state_d = S_JALRADR;
          is_lui:       state_d = S_EXECI;
`endif
          default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_MEMADR: state_d = is_st ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD, S_MEMWRITE: begin
        if (bus.mem_ready) begin
          state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
        end else if (tmo) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_MEMWB:         state_d = S_FETCH;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB:         state_d = S_FETCH;
      S_BRANCH: begin
        if (funct3[2:1] == 2'b01) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = S_FETCH;
        end
      end
`ifdef CTRL_JUMP_EN
      S_JALRADR: state_d = S_JUMP;
      S_JUMP:    state_d = S_ALUWB;
`endif
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_write = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    imm_src       = 3'b000;
    alu_control   = 4'd0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          ir_write    = bus.mem_ready;
          pc_write    = bus.mem_ready;
          result_src  = 2'b10;
          alu_src_b   = 2'b10;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = is_jal ? 3'b011 : 3'b010;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = is_st ? 3'b001 : 3'b000;
        end
        S_MEMREAD: begin
          bus.mem_req = 1'b1;
          adr_src     = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          bus.mem_req   = 1'b1;
          bus.mem_write = 1'b1;
          adr_src       = 1'b1;
        end
        S_EXECR: begin
          alu_src_a   = 2'b10;
          alu_control = alu_dec(funct3, funct7_5, 1'b1);
        end
        S_EXECI: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = alu_dec(funct3, funct7_5, 1'b0);
`ifdef CTRL_JUMP_EN
          if (is_lui) begin
            alu_src_a   = 2'b11;
            imm_src     = 3'b100;
            alu_control = 4'd0;
          end
`endif
        end
        S_ALUWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a   = 2'b10;
          alu_control = 4'd1;
          pc_write    = br_taken(funct3, zero, msb, sltu);
        end
`ifdef CTRL_JUMP_EN
        S_JALRADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller - directed and random instruction streams
// checked cycle by cycle against an instruction-level sequence model.
module tb_multicycle_controller;
  localparam int TMO = 4;

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [21:0] RST_M = 22'h3FFFF8;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero, msb, sltu;
  logic       adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       trap;
  logic [1:0] trap_cause;

  multicycle_controller_if bus ();

  multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .msb(msb), .sltu(sltu),
    .bus(bus.master),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  logic [21:0] obs;
  assign obs = {bus.mem_req, bus.mem_write, adr_src, ir_write, pc_write,
                reg_write, result_src, alu_src_a, alu_src_b, imm_src,
                alu_control, trap, trap_cause};

  int         tests = 0;
  int         fails = 0;
  logic       trap_exp = 1'b0;
  logic [1:0] cause_exp = 2'b00;

  function automatic logic [21:0] mk(
    input logic req, input logic wr, input logic adr, input logic ir,
    input logic pc, input logic rw, input logic [1:0] rs,
    input logic [1:0] a, input logic [1:0] b, input logic [2:0] imm,
    input logic [3:0] alu
  );
    return {req, wr, adr, ir, pc, rw, rs, a, b, imm, alu,
            trap_exp, cause_exp};
  endfunction

  function automatic logic [21:0] msk(
    input logic adr, input logic rs, input logic a, input logic b,
    input logic imm, input logic alu
  );
    return {2'b11, adr, 3'b111, {2{rs}}, {2{a}}, {2{b}}, {3{imm}},
            {4{alu}}, 3'b111};
  endfunction

  function automatic logic [3:0] alu_ref(
    input logic [2:0] f3, input logic f7, input logic r
  );
    case (f3)
      3'd0:    return (r && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd2;
      3'd2:    return 4'd3;
      3'd3:    return 4'd4;
      3'd4:    return 4'd5;
      3'd5:    return f7 ? 4'd7 : 4'd6;
      3'd6:    return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic taken_ref(
    input logic [2:0] f3, input logic z, input logic m, input logic s
  );
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return m;
      3'd5:    return !m;
      3'd6:    return s;
      3'd7:    return !s;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc(input string tag, input logic [21:0] e,
                     input logic [21:0] m);
    @(negedge clk);
    tests++;
    assert ((obs & m) === (e & m)) else begin
      fails++;
      $error("FAIL %s: got %h want %h mask %h", tag, obs & m, e & m, m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ready();
    bus.mem_ready = 1'($urandom);
  endtask

  task automatic mem_wait(input int kind, input int delay, output logic to);
    logic r;
    to = 1'b0;
    for (int i = 0; i < 64; i++) begin
      r = (i >= delay);
      bus.mem_ready = r;
      case (kind)
        0: cyc("fetch", mk(1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'd2, 2'd0,
                           2'd2, 3'd0, 4'd0),
               msk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        1: cyc("memread", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0,
                             2'd0, 2'd0, 3'd0, 4'd0),
               msk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        default: cyc("memwrite", mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                    2'd0, 2'd0, 2'd0, 3'd0, 4'd0),
                     msk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      endcase
      if (r) return;
      if (TMO != 0 && i + 1 == TMO) begin
        to = 1'b1;
        return;
      end
    end
    to = 1'b1;
  endtask

  task automatic enter_trap(input logic [1:0] c);
    trap_exp  = 1'b1;
    cause_exp = c;
    for (int i = 0; i < 2; i++) begin
      rnd_ready();
      cyc("trap", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                     2'd0, 3'd0, 4'd0),
          msk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      rnd_ready();
      cyc("reset", 22'h0, RST_M);
    end
    reset     = 1'b0;
    trap_exp  = 1'b0;
    cause_exp = 2'b00;
  endtask

  task automatic aluwb();
    rnd_ready();
    cyc("aluwb", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0,
                    2'd0, 3'd0, 4'd0),
        msk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic run_instr(
    input logic [6:0] op, input logic [2:0] f3, input logic f7,
    input logic z, input logic m, input logic s,
    input int fd, input int md
  );
    logic  to, legal;
    string t;
    opcode   = op;
    funct3   = f3;
    funct7_5 = f7;
    zero     = z;
    msb      = m;
    sltu     = s;
    mem_wait(0, fd, to);
    if (to) begin
      enter_trap(2'b10);
      return;
    end
    rnd_ready();
    cyc("decode", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1,
                     2'd1, (op == OP_JAL) ? 3'd3 : 3'd2, 4'd0),
        msk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    if (op == OP_LD || op == OP_ST) begin
      rnd_ready();
      cyc("memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2,
                       2'd1, (op == OP_ST) ? 3'd1 : 3'd0, 4'd0),
          msk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
      mem_wait((op == OP_ST) ? 2 : 1, md, to);
      if (to) begin
        enter_trap(2'b10);
        return;
      end
      if (op == OP_LD) begin
        rnd_ready();
        cyc("memwb", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0,
                        2'd0, 3'd0, 4'd0),
            msk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end else if (op == OP_R || op == OP_I) begin
      t = (op == OP_R) ? "execr" : "execi";
      rnd_ready();
      cyc(t, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2,
                (op == OP_R) ? 2'd0 : 2'd1, 3'd0,
                alu_ref(f3, f7, op == OP_R)),
          msk(1'b0, 1'b0, 1'b1, 1'b1, op == OP_I, 1'b1));
      aluwb();
    end else if (op == OP_B) begin
      legal = !(f3 == 3'd2 || f3 == 3'd3);
      rnd_ready();
      cyc("branch", mk(1'b0, 1'b0, 1'b0, 1'b0,
                       legal && taken_ref(f3, z, m, s), 1'b0, 2'd0,
                       2'd2, 2'd0, 3'd0, 4'd1),
          msk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
      if (!legal) enter_trap(2'b01);
    end
`ifdef CTRL_JUMP_EN
    else if (op == OP_JAL || op == OP_JALR) begin
      if (op == OP_JALR) begin
        rnd_ready();
        cyc("jalradr", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
                          2'd2, 2'd1, 3'd0, 4'd0),
            msk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
      end
      rnd_ready();
      cyc("jump", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1,
                     2'd2, 3'd0, 4'd0),
          msk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
      aluwb();
    end else if (op == OP_LUI) begin
      rnd_ready();
      cyc("lui", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3,
                    2'd1, 3'd4, 4'd0),
          msk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
      aluwb();
    end
`endif
    else begin
      enter_trap(2'b01);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic to;
    reset = 1'b1; opcode = OP_R; funct3 = 3'd0; funct7_5 = 1'b0;
    zero = 1'b0; msb = 1'b0; sltu = 1'b0; bus.mem_ready = 1'b0;
    do_reset(2);

    run_instr(OP_R, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr(OP_R, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
    run_instr(OP_I, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    run_instr(OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3);
    run_instr(OP_B, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr(OP_B, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr(OP_B, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    do_reset(2);
    run_instr(OP_ST, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 9);
    do_reset(2);
    run_instr(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    if (trap_exp) do_reset(2);
    run_instr(OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    if (trap_exp) do_reset(2);

    opcode = OP_LD; funct3 = 3'd2;
    mem_wait(0, 0, to);
    rnd_ready();
    cyc("decode", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1,
                     2'd1, 3'd2, 4'd0),
        msk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    rnd_ready();
    cyc("memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2,
                     2'd1, 3'd0, 4'd0),
        msk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    for (int i = 0; i < 2; i++) begin
      bus.mem_ready = 1'b0;
      cyc("memread", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                        2'd0, 3'd0, 4'd0),
          msk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    do_reset(1);
    run_instr(OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3);
    run_instr(OP_R, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0);
    do_reset(2);

    for (int k = 0; k < 150; k++) begin
      logic [6:0] op;
      int         sel, fd, md;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    op = OP_R;
        2:       op = OP_I;
        3:       op = OP_LD;
        4:       op = OP_ST;
        5:       op = OP_B;
        6:       op = OP_JAL;
        7:       op = OP_JALR;
        8:       op = OP_LUI;
        default: op = 7'($urandom);
      endcase
      fd = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 3));
      md = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 3));
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), fd, md);
      if (trap_exp) do_reset(int'($urandom_range(1, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
